dmem_axi_master: RTL and testbench



---
 rtl/dmem_axi_pkg.sv | 20 ++
 rtl/dmem_axi_master.sv | 171 +++++++++++++++++
 tb/tb_dmem_axi_master.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_axi_pkg.sv
// Shared types and AXI attribute constants for the data-memory AXI master.
// Pure declarations; no logic.
// No handshake of its own.
package dmem_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } dmem_axi_state_e;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dmem_axi_master.sv
// Bridges the core's data-memory request port to single-beat AXI master channels.
// Latency: 4 cycles per load/store minimum (request, address, response, DONE).
// Backpressure: stall_o freezes the pipeline; optional sticky bus error via DMEM_BUS_ERR_EN.
module dmem_axi_master
    import dmem_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_ren,
    input  logic                  req_wen,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  stall_o,
    output logic [ADDR_W-1:0]     ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
`ifdef DMEM_BUS_ERR_EN
    ,
    output logic                  err_o,
    output logic [ADDR_W-1:0]     err_addr_o
`endif
);

    dmem_axi_state_e     state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                aw_pend_q, aw_pend_d;
    logic                w_pend_q, w_pend_d;
    logic                bus_err;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        stall_o   = 1'b1;
        case (state_q)
            IDLE: begin
                stall_o = req_ren | req_wen;
                if (req_wen) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    state_d   = WR_REQ;
                end else if (req_ren) begin
                    addr_d  = req_addr;
                    state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (RVALID) begin
                    rdata_d = RDATA;
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; leave once neither is outstanding
                if (AWREADY) aw_pend_d = 1'b0;
                if (WREADY)  w_pend_d  = 1'b0;
                if ((!aw_pend_q || AWREADY) && (!w_pend_q || WREADY)) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (BVALID) state_d = DONE;
            end
            DONE: begin
                // The finished request is still held by MEM this cycle, so do not resample it
                stall_o = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ARVALID   = (state_q == RD_ADDR);
    assign ARADDR    = addr_q;
    assign ARLEN     = AXI_LEN_SINGLE;
    assign ARSIZE    = AXI_SIZE_WORD;
    assign ARBURST   = AXI_BURST_INCR;
    assign RREADY    = (state_q == RD_DATA);
    assign AWVALID   = aw_pend_q;
    assign AWADDR    = addr_q;
    assign AWLEN     = AXI_LEN_SINGLE;
    assign AWSIZE    = AXI_SIZE_WORD;
    assign AWBURST   = AXI_BURST_INCR;
    assign WVALID    = w_pend_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign BREADY    = (state_q == WR_RESP);
    assign rsp_rdata = rdata_q;

    assign bus_err = (RVALID && RREADY && (RRESP != AXI_RESP_OKAY)) ||
                     (BVALID && BREADY && (BRESP != AXI_RESP_OKAY));

`ifdef DMEM_BUS_ERR_EN
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;

    // First failing address is kept; later errors only keep the flag set
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (bus_err && !err_q) begin
            err_q      <= 1'b1;
            err_addr_q <= addr_q;
        end
    end

    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
`else
    logic unused_bus_err;
    assign unused_bus_err = bus_err;
`endif

endmodule

// File: tb/tb_dmem_axi_master.sv
// Bench for dmem_axi_master: directed loads/stores against a configurable slave,
// with a transaction-level model checked every cycle. Honours DMEM_BUS_ERR_EN.
module tb_dmem_axi_master;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ren = 1'b0, req_wen = 1'b0;
    logic [3:0]  req_wstrb = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] rsp_rdata;
    logic        stall_o;
    logic [31:0] ARADDR, AWADDR, WDATA;
    logic [7:0]  ARLEN, AWLEN;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST;
    logic        ARVALID, RREADY, AWVALID, WVALID, BREADY;
    logic [3:0]  WSTRB;
    logic        ARREADY = 1'b0, RVALID = 1'b0, AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
    logic [31:0] RDATA = '0;
    logic [1:0]  RRESP = '0, BRESP = '0;
`ifdef DMEM_BUS_ERR_EN
    logic        err_o;
    logic [31:0] err_addr_o;
`endif

    always #5 ACLK = ~ACLK;

    dmem_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_addr(req_addr), .req_ren(req_ren), .req_wen(req_wen),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_rdata(rsp_rdata), .stall_o(stall_o),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
`ifdef DMEM_BUS_ERR_EN
        , .err_o(err_o), .err_addr_o(err_addr_o)
`endif
    );

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : ~a;
    endfunction

    // Pipeline (MEM stage) and expected-transaction scoreboard
    req_t pipe_q[$];
    req_t cur = '0;
    txn_t exp_q[$];

    // Slave configuration and state
    int ar_wait = 0, r_delay = 0, aw_wait = 0, w_wait = 0, b_delay = 0;
    logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    int ar_left = 0, r_left = 0, aw_left = 0, w_left = 0, b_left = 0;
    logic r_pend = 0, b_pend = 0, aw_done = 0, w_done = 0;
    logic [31:0] rd_dat = '0;

    // Samples taken by the monitor, consumed by the driver after the next edge
    logic s_arv = 0, s_arr = 0, s_rv = 0, s_rr = 0, s_awv = 0, s_awr = 0;
    logic s_wv = 0, s_wr = 0, s_bv = 0, s_br = 0, s_stall = 0;
    logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
    logic [3:0]  p_wstrb = '0;

    // Model state
    logic [31:0] mdl_rdata = '0;
    logic        mdl_err = 0;
    logic [31:0] mdl_err_addr = '0;
    logic        done_prev = 0;
    logic        seen_ar = 0, seen_aw = 0, seen_w = 0;
    logic        m_rd_front, m_wr_front, m_r_hs, m_b_hs, m_exp_stall;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, arv_cyc = 0, stall_cnt = 0;
    logic [31:0] last_araddr = '0;
    logic [3:0]  last_wstrb = '0;

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            chk("rst_vld_rdy_stall", {58'd0, ARVALID, RREADY, AWVALID, WVALID, BREADY, stall_o}, 64'd0);
            chk("rst_rdata", rsp_rdata, 64'd0);
            chk("rst_addr_regs", {ARADDR, AWADDR}, 64'd0);
            chk("rst_wdata_regs", {WDATA, WSTRB}, 64'd0);
`ifdef DMEM_BUS_ERR_EN
            chk("rst_err", {err_o, err_addr_o}, 64'd0);
`endif
            mdl_rdata = '0; mdl_err = 0; mdl_err_addr = '0; done_prev = 0;
            seen_ar = 0; seen_aw = 0; seen_w = 0;
            {s_arv, s_arr, s_rv, s_rr, s_awv, s_awr, s_wv, s_wr, s_bv, s_br, s_stall} = '0;
        end else begin
            // Stall is high whenever a request is present, except the one cycle after completion
            m_exp_stall = done_prev ? 1'b0 : (req_ren | req_wen);
            chk("stall", stall_o, m_exp_stall);
            chk("rsp_rdata", rsp_rdata, mdl_rdata);
`ifdef DMEM_BUS_ERR_EN
            chk("err_o", err_o, mdl_err);
            chk("err_addr_o", err_addr_o, mdl_err_addr);
`endif
            if (s_arv && !s_arr) begin
                chk("ar_hold", ARVALID, 1);
                chk("araddr_stable", ARADDR, p_araddr);
            end
            if (s_awv && !s_awr) begin
                chk("aw_hold", AWVALID, 1);
                chk("awaddr_stable", AWADDR, p_awaddr);
            end
            if (s_wv && !s_wr) begin
                chk("w_hold", WVALID, 1);
                chk("wdata_stable", {WDATA, WSTRB}, {p_wdata, p_wstrb});
            end
            m_rd_front = (exp_q.size() != 0) && !exp_q[0].wr;
            m_wr_front = (exp_q.size() != 0) && exp_q[0].wr;
            if (ARVALID || RREADY) chk("read_chan_for_load", m_rd_front, 1);
            if (AWVALID || WVALID || BREADY) chk("write_chan_for_store", m_wr_front, 1);
            if (BREADY) chk("bready_after_aw_w", seen_aw && seen_w, 1);
            if (RREADY) chk("rready_after_ar", seen_ar, 1);
            if (ARVALID) arv_cyc++;
            if (ARVALID && ARREADY && m_rd_front) begin
                ar_cnt++;
                last_araddr = ARADDR;
                chk("ar_single", seen_ar, 0);
                chk("araddr", ARADDR, exp_q[0].addr);
                seen_ar = 1;
            end
            if (AWVALID && AWREADY && m_wr_front) begin
                aw_cnt++;
                chk("aw_single", seen_aw, 0);
                chk("awaddr", AWADDR, exp_q[0].addr);
                seen_aw = 1;
            end
            if (WVALID && WREADY && m_wr_front) begin
                w_cnt++;
                last_wstrb = WSTRB;
                chk("w_single", seen_w, 0);
                chk("wdata_wstrb", {WDATA, WSTRB}, {exp_q[0].wdata, exp_q[0].wstrb});
                seen_w = 1;
            end
            m_r_hs = RVALID && RREADY && m_rd_front;
            m_b_hs = BVALID && BREADY && m_wr_front;
            if (m_r_hs) mdl_rdata = RDATA;
            if ((m_r_hs && RRESP != 2'b00) || (m_b_hs && BRESP != 2'b00)) begin
                if (!mdl_err) mdl_err_addr = exp_q[0].addr;
                mdl_err = 1;
            end
            if (m_r_hs || m_b_hs) begin
                void'(exp_q.pop_front());
                seen_ar = 0; seen_aw = 0; seen_w = 0;
            end
            done_prev = m_r_hs || m_b_hs;
            if (stall_o) stall_cnt++;
            s_arv = ARVALID; s_arr = ARREADY; s_rv = RVALID; s_rr = RREADY;
            s_awv = AWVALID; s_awr = AWREADY; s_wv = WVALID; s_wr = WREADY;
            s_bv = BVALID; s_br = BREADY; s_stall = stall_o;
            p_araddr = ARADDR; p_awaddr = AWADDR; p_wdata = WDATA; p_wstrb = WSTRB;
        end
    end

    task automatic drive();
        ARREADY   = (ar_left == 0);
        RVALID    = r_pend && (r_left == 0);
        RDATA     = RVALID ? rd_dat : 32'h0;
        RRESP     = RVALID ? rresp_cfg : 2'b00;
        AWREADY   = (aw_left == 0);
        WREADY    = (w_left == 0);
        BVALID    = b_pend && (b_left == 0);
        BRESP     = BVALID ? bresp_cfg : 2'b00;
        req_ren   = cur.ren;
        req_wen   = cur.wen;
        req_addr  = cur.addr;
        req_wdata = cur.wdata;
        req_wstrb = cur.wstrb;
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
        if (s_rv && s_rr) r_pend = 0;
        else if (r_pend && r_left > 0) r_left--;
        if (s_arv && s_arr) begin
            r_pend = 1; r_left = r_delay; ar_left = ar_wait; rd_dat = mem_rd(p_araddr);
        end else if (s_arv && ar_left > 0) ar_left--;
        if (s_bv && s_br) b_pend = 0;
        else if (b_pend && b_left > 0) b_left--;
        if (s_awv && s_awr) begin aw_done = 1; aw_left = aw_wait; end
        else if (s_awv && aw_left > 0) aw_left--;
        if (s_wv && s_wr) begin w_done = 1; w_left = w_wait; end
        else if (s_wv && w_left > 0) w_left--;
        if (aw_done && w_done) begin
            b_pend = 1; b_left = b_delay; aw_done = 0; w_done = 0;
        end
        if (!s_stall) begin
            if (pipe_q.size() != 0) begin
                cur = pipe_q.pop_front();
                if (cur.ren || cur.wen)
                    exp_q.push_back('{wr: cur.wen, addr: cur.addr, wdata: cur.wdata, wstrb: cur.wstrb});
            end else cur = '0;
        end
        drive();
    endtask

    task automatic set_cfg(input int aw8, input int rd, input int aww, input int ww, input int bd,
                           input logic [1:0] rr, input logic [1:0] br);
        ar_wait = aw8; r_delay = rd; aw_wait = aww; w_wait = ww; b_delay = bd;
        rresp_cfg = rr; bresp_cfg = br;
        ar_left = aw8; aw_left = aww; w_left = ww;
    endtask

    task automatic flush();
        pipe_q.delete(); exp_q.delete(); cur = '0;
        r_pend = 0; b_pend = 0; aw_done = 0; w_done = 0;
        ar_left = ar_wait; aw_left = aw_wait; w_left = w_wait; r_left = 0; b_left = 0;
        drive();
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((pipe_q.size() != 0 || exp_q.size() != 0 || cur.ren || cur.wen) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL %s: timeout, %0d transactions still outstanding, required 0", nm, exp_q.size());
        end
    endtask

    task automatic push_ld(input logic [31:0] a);
        pipe_q.push_back('{ren: 1'b1, wen: 1'b0, addr: a, wdata: 32'h0, wstrb: 4'h0});
    endtask

    task automatic push_st(input logic ren, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        pipe_q.push_back('{ren: ren, wen: 1'b1, addr: a, wdata: d, wstrb: s});
    endtask

    int s0, a0, aw0, w0, v0;

    initial begin
        drive();
        repeat (3) step();
        ARESETn = 1'b1;
        chk("tie_ar_attr", {ARLEN, ARSIZE, ARBURST}, {8'd0, 3'b010, 2'b01});
        chk("tie_aw_attr", {AWLEN, AWSIZE, AWBURST}, {8'd0, 3'b010, 2'b01});
        step();

        // Load, zero-wait slave
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
        s0 = stall_cnt; a0 = ar_cnt;
        push_ld(32'h100);
        wait_idle("t1_load");
        chk("t1_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("t1_stall_cycles", s0 + 3, stall_cnt);
        chk("t1_ar_count", a0 + 1, ar_cnt);

        // Store, W accepted two cycles before AW
        set_cfg(0, 0, 2, 0, 0, 2'b00, 2'b00);
        s0 = stall_cnt; aw0 = aw_cnt; w0 = w_cnt;
        push_st(1'b0, 32'h200, 32'h12345678, 4'b0011);
        wait_idle("t2_store");
        chk("t2_aw_count", aw0 + 1, aw_cnt);
        chk("t2_w_count", w0 + 1, w_cnt);
        chk("t2_wstrb", last_wstrb, 4'b0011);
        chk("t2_stall_cycles", s0 + 5, stall_cnt);

        // Back-to-back loads, request held across DONE
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
        s0 = stall_cnt; a0 = ar_cnt;
        push_ld(32'h100);
        push_ld(32'h104);
        wait_idle("t3_b2b");
        chk("t3_ar_count", a0 + 2, ar_cnt);
        chk("t3_last_araddr", last_araddr, 32'h104);
        chk("t3_rdata", rsp_rdata, 32'hFFFFFEFB);
        chk("t3_stall_cycles", s0 + 6, stall_cnt);

        // Simultaneous load and store: store wins
        a0 = ar_cnt; aw0 = aw_cnt; v0 = arv_cyc;
        push_st(1'b1, 32'h240, 32'hCAFEF00D, 4'b1111);
        wait_idle("t4_both");
        chk("t4_ar_count", a0, ar_cnt);
        chk("t4_arvalid_cycles", v0, arv_cyc);
        chk("t4_aw_count", aw0 + 1, aw_cnt);

        // AR backpressure for 5 cycles
        set_cfg(5, 0, 0, 0, 0, 2'b00, 2'b00);
        s0 = stall_cnt; v0 = arv_cyc;
        push_ld(32'h10C);
        wait_idle("t5_ar_bp");
        chk("t5_arvalid_cycles", v0 + 6, arv_cyc);
        chk("t5_stall_cycles", s0 + 8, stall_cnt);
        chk("t5_rdata", rsp_rdata, 32'hFFFFFEF3);

        // Reset while waiting in the read-data phase
        set_cfg(0, 20, 0, 0, 0, 2'b00, 2'b00);
        push_ld(32'h180);
        for (int i = 0; i < 10 && !s_rr; i++) step();
        chk("t6_reached_rd_data", s_rr, 1);
        ARESETn = 1'b0;
        flush();
        #1;
        chk("t6_async_clear", {58'd0, ARVALID, RREADY, AWVALID, WVALID, BREADY, stall_o}, 64'd0);
        step();
        step();
        ARESETn = 1'b1;
        step();
        chk("t6_after_reset", {58'd0, ARVALID, RREADY, AWVALID, WVALID, BREADY, stall_o}, 64'd0);
        chk("t6_rdata_cleared", rsp_rdata, 64'd0);

        // Error responses complete normally
        set_cfg(0, 0, 0, 0, 0, 2'b10, 2'b00);
        push_ld(32'h300);
        wait_idle("t7_rd_err");
        chk("t7_rdata", rsp_rdata, 32'hFFFFFCFF);
`ifdef DMEM_BUS_ERR_EN
        chk("t7_err_o", err_o, 1);
        chk("t7_err_addr", err_addr_o, 32'h300);
`endif
        set_cfg(0, 0, 0, 2, 3, 2'b00, 2'b11);
        s0 = stall_cnt;
        push_st(1'b0, 32'h340, 32'h0BADF00D, 4'b1100);
        wait_idle("t8_wr_err");
        chk("t8_stall_cycles", s0 + 8, stall_cnt);
`ifdef DMEM_BUS_ERR_EN
        chk("t8_err_addr_first", err_addr_o, 32'h300);
`endif
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
